// File: rtl/zr_pkg.sv
// Shared types and helpers for the zero-run expander and its companion
// trailing-zero counter.
//   zr_state_t : expander FSM state encoding
//   cw_f       : count width needed to represent 0..w inclusive
package zr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } zr_state_t;

    // Count width shared with the trailing-zero counter (0..w needs clog2(w)+1 bits).
    function automatic int cw_f(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/zero_run_expander.sv
// Zero-run expander: takes a zero-count N and serializes the canonical word
// W = (N < DATA_WIDTH) ? (1 << N) : 0, LSB first, one bit per handshake.
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   din/din_valid       : zero-count N input (CW bits), valid
//   din_ready           : combinational; block accepts N this cycle
//   dout/dout_valid     : current serial bit of W, valid
//   dout_last           : dout is bit DATA_WIDTH-1 of W
//   dout_ready          : sink accepts dout this cycle
//   err_clamp           : one-cycle pulse after accepting N > DATA_WIDTH
module zero_run_expander
    import zr_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    localparam int unsigned CW         = cw_f(DATA_WIDTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          dout,
    output logic          dout_valid,
    output logic          dout_last,
    input  logic          dout_ready,
    output logic          err_clamp
);

    localparam int unsigned    BW     = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]  DW_C   = CW'(DATA_WIDTH);
    localparam logic [BW-1:0]  LAST_C = BW'(DATA_WIDTH - 1);

    zr_state_t     state_q, state_d;
    logic [CW-1:0] nc_q, nc_d;
    logic [BW-1:0] bit_idx_q, bit_idx_d;
    logic          dout_q, dout_d;
    logic          dout_valid_q, dout_valid_d;
    logic          dout_last_q, dout_last_d;
    logic          err_clamp_q, err_clamp_d;
    logic          load;
    logic [CW-1:0] nc_in;
    logic [BW-1:0] idx_next;

    // Bit value of the canonical word at a given index; Nc == DATA_WIDTH is all-zero.
    function automatic logic word_bit_f(input logic [BW-1:0] idx, input logic [CW-1:0] nc);
        return (CW'(idx) == nc) && (nc < DW_C);
    endfunction

    // Next-state, next-output and handshake logic.
    always_comb begin
        state_d      = state_q;
        nc_d         = nc_q;
        bit_idx_d    = bit_idx_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        err_clamp_d  = 1'b0;

        // In SHIFT a new count can only enter on the final-bit handshake.
        din_ready = (state_q == IDLE) || (dout_last_q && dout_ready);
        load      = din_valid && din_ready;
        nc_in     = (din > DW_C) ? DW_C : din;
        idx_next  = bit_idx_q + BW'(1);

        if (load) begin
            state_d      = SHIFT;
            nc_d         = nc_in;
            bit_idx_d    = '0;
            err_clamp_d  = (din > DW_C);
            dout_valid_d = 1'b1;
            dout_d       = word_bit_f('0, nc_in);
            dout_last_d  = (LAST_C == '0);
        end else if ((state_q == SHIFT) && dout_ready) begin
            if (!dout_last_q) begin
                bit_idx_d    = idx_next;
                dout_valid_d = 1'b1;
                dout_d       = word_bit_f(idx_next, nc_q);
                dout_last_d  = (idx_next == LAST_C);
            end else begin
                state_d      = IDLE;
                bit_idx_d    = '0;
                dout_valid_d = 1'b0;
                dout_d       = 1'b0;
                dout_last_d  = 1'b0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            nc_q         <= '0;
            bit_idx_q    <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            err_clamp_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            nc_q         <= nc_d;
            bit_idx_q    <= bit_idx_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            err_clamp_q  <= err_clamp_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign err_clamp  = err_clamp_q;

endmodule

// File: tb/tb_zero_run_expander.sv
// Self-checking bench for zero_run_expander at DATA_WIDTH=8.
module tb_zero_run_expander;

    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       dout;
    logic       dout_valid;
    logic       dout_last;
    logic       dout_ready = 1'b1;
    logic       err_clamp;

    zero_run_expander #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .dout_ready (dout_ready),
        .err_clamp  (err_clamp)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Driver-side description of the word currently offered on din.
    logic [7:0] cur_word = '0;
    logic [3:0] cur_n    = '0;
    logic       cur_err  = 1'b0;

    // Scoreboard state.
    logic [1:0] exp_q[$];
    int         n_q[$];
    logic       err_pending = 1'b0;
    logic       stall_prev = 1'b0;
    logic       prev_dout = 1'b0;
    logic       prev_last = 1'b0;
    logic [7:0] assembled = '0;
    int         bit_pos = 0;
    int         pop_cnt = 0;
    int         words_done = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         run = 0;
    int         last_run = 0;

    function automatic int tz_f(input logic [7:0] w);
        for (int i = 0; i < 8; i++) if (w[i]) return i;
        return 8;
    endfunction

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            logic       nxt_err;
            logic [1:0] e;
            cyc++;
            check("err_clamp", 32'(err_clamp), 32'(err_pending));
            if (stall_prev) begin
                check("hold_valid", 32'(dout_valid), 32'd1);
                check("hold_dout", 32'(dout), 32'(prev_dout));
                check("hold_last", 32'(dout_last), 32'(prev_last));
            end
            stall_prev = dout_valid && !dout_ready;
            prev_dout  = dout;
            prev_last  = dout_last;
            run = dout_valid ? run + 1 : 0;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_bit: got dout=%0d expected no output", dout);
                end else begin
                    e = exp_q.pop_front();
                    check("bit", 32'(dout), 32'(e[0]));
                    check("last", 32'(dout_last), 32'(e[1]));
                end
                assembled[bit_pos[2:0]] = dout;
                bit_pos++;
                pop_cnt++;
                if (dout_last) begin
                    if (n_q.size() != 0) check("round_trip_tz", 32'(tz_f(assembled)), 32'(n_q.pop_front()));
                    bit_pos = 0;
                    words_done++;
                    last_run = run;
                end
            end
            nxt_err = 1'b0;
            if (din_valid && din_ready) begin
                for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), cur_word[i]});
                n_q.push_back((cur_n > 8) ? 8 : int'(cur_n));
                nxt_err = cur_err;
                acc_cyc = cyc;
            end
            err_pending = nxt_err;
        end
    end

    // dout_ready generator: 0 = always 1, 1 = random, 2 = pattern 1,0,0,1 repeating.
    int ready_mode = 0;
    int pc = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1:       dout_ready = 1'($urandom_range(0, 1));
            2:       dout_ready = ((pc % 4) == 0) || ((pc % 4) == 3);
            default: dout_ready = 1'b1;
        endcase
        pc++;
    end

    int sent_words = 0;

    // Offer one count; called and returns at posedge+#1.
    task automatic send(input logic [3:0] n, input logic [7:0] w, input logic er);
        bit acc = 1'b0;
        din = n; din_valid = 1'b1; cur_n = n; cur_word = w; cur_err = er;
        for (int b = 0; b < 300 && !acc; b++) begin
            @(negedge clk);
            acc = din_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            tests++; fails++;
            $display("FAIL din_accept_timeout: got no accept expected accept for N=%0d", n);
        end else begin
            sent_words++;
        end
    endtask

    task automatic wait_words();
        for (int b = 0; b < 5000 && words_done < sent_words; b++) @(negedge clk);
        check("words_done", 32'(words_done), 32'(sent_words));
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete(); n_q.delete();
        err_pending = 0; stall_prev = 0; bit_pos = 0; run = 0;
    endtask

    typedef struct {
        logic [3:0] n;
        logic [7:0] word;
        logic       err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int cnt;
        int a0;
        int a1;
        int base;
        vecs[0] = '{4'd0,  8'h01, 1'b0};
        vecs[1] = '{4'd1,  8'h02, 1'b0};
        vecs[2] = '{4'd3,  8'h08, 1'b0};
        vecs[3] = '{4'd6,  8'h40, 1'b0};
        vecs[4] = '{4'd7,  8'h80, 1'b0};
        vecs[5] = '{4'd8,  8'h00, 1'b0};
        vecs[6] = '{4'd9,  8'h00, 1'b1};
        vecs[7] = '{4'd12, 8'h00, 1'b1};
        vecs[8] = '{4'd15, 8'h00, 1'b1};
        vecs[9] = '{4'd5,  8'h20, 1'b0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout_valid", 32'(dout_valid), 32'd0);
        check("rst_dout", 32'(dout), 32'd0);
        check("rst_dout_last", 32'(dout_last), 32'd0);
        check("rst_err_clamp", 32'(err_clamp), 32'd0);
        check("rst_din_ready", 32'(din_ready), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Table of single words with idle gaps.
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].n, vecs[i].word, vecs[i].err);
            din_valid = 1'b0;
            wait_words();
        end

        // N=3: din_ready low for exactly 7 cycles.
        send(4'd3, 8'h08, 1'b0);
        din_valid = 1'b0;
        cnt = 0;
        for (int b = 0; b < 20; b++) begin
            @(negedge clk);
            if (din_ready) break;
            cnt++;
        end
        check("n3_ready_low_cycles", 32'(cnt), 32'd7);
        wait_words();

        // N=0 then N=8 back-to-back: second accepted on first word's last bit, no gap.
        send(4'd0, 8'h01, 1'b0);
        a0 = acc_cyc;
        send(4'd8, 8'h00, 1'b0);
        a1 = acc_cyc;
        din_valid = 1'b0;
        wait_words();
        check("b2b_accept_spacing", 32'(a1 - a0), 32'd8);
        check("b2b_valid_run", 32'(last_run), 32'd16);

        // N=5 under the 1,0,0,1 ready pattern.
        ready_mode = 2;
        send(4'd5, 8'h20, 1'b0);
        din_valid = 1'b0;
        wait_words();
        ready_mode = 0;

        // Reset after the 4th bit of N=2, then N=1.
        base = pop_cnt;
        send(4'd2, 8'h04, 1'b0);
        din_valid = 1'b0;
        for (int b = 0; b < 50 && pop_cnt < base + 4; b++) @(negedge clk);
        check("pre_reset_bits", 32'(pop_cnt - base), 32'd4);
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_sb();
        sent_words--;
        #1;
        check("midrst_dout_valid", 32'(dout_valid), 32'd0);
        check("midrst_din_ready", 32'(din_ready), 32'd1);
        check("midrst_dout_last", 32'(dout_last), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(4'd1, 8'h02, 1'b0);
        din_valid = 1'b0;
        wait_words();

        // Round trip: 1000 random counts, continuous input, random backpressure.
        ready_mode = 1;
        for (int k = 0; k < 1000; k++) begin
            logic [3:0] n;
            logic [7:0] w;
            n = 4'($urandom_range(0, 8));
            w = 8'd1 << n;
            send(n, w, 1'b0);
        end
        din_valid = 1'b0;
        wait_words();
        ready_mode = 0;

        check("sb_bits_left", 32'(exp_q.size()), 32'd0);
        check("sb_words_left", 32'(n_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
